// File: rtl/intra_edge_filter.sv
// Intra edge smoothing filter.
// Streams one above/left edge through a 5-tap smoothing kernel selected by
// strength (0 = passthrough, 1..3 = kernel). Samples enter and leave on
// valid/ready handshakes in order; strength and length are latched on start.
//
// state | meaning
// IDLE  | waiting for an accepted start, no input taken
// RUN   | accepting samples; output i is produced when sample i+2 arrives
// FLUSH | input closed; remaining outputs use right-edge replication
// DONE  | one-cycle done pulse, then back to IDLE

module intra_edge_filter #(
   parameter int BIT_DEPTH = 10,
   parameter int MAX_SZ    = 129
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [9:0]           strength,
   input  logic [7:0]           sz,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_DEPTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_DEPTH-1:0] out_data,
   output logic                 out_last,
   output logic                 done
);

   localparam int ACC_W = BIT_DEPTH + 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state;
   logic [1:0]           str_q;
   logic [7:0]           sz_q;
   logic [7:0]           in_cnt;
   logic [7:0]           prod_cnt;
   logic [BIT_DEPTH-1:0] win    [5];
   logic [BIT_DEPTH-1:0] win_nx [5];

   logic                 slot_free;
   logic                 in_fire;
   logic                 shift_en;
   logic                 produce;
   logic                 start_ok;
   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     rnd;
   logic [BIT_DEPTH-1:0] filt;
   logic [BIT_DEPTH-1:0] res;

   // Handshake qualifiers; a new output may only be produced when the
   // output register is empty or being drained this cycle.
   always_comb begin
      slot_free = !out_valid || out_ready;
      in_ready  = (state == RUN) && slot_free && (in_cnt < sz_q);
      in_fire   = in_valid && in_ready;
      produce   = ((state == RUN) && in_fire && (in_cnt >= 8'd2)) ||
                  ((state == FLUSH) && slot_free && (prod_cnt < sz_q));
      shift_en  = ((state == RUN) && in_fire) || ((state == FLUSH) && produce);
      start_ok  = start && (sz != 8'd0) && (int'(sz) <= MAX_SZ);
   end

   // Next window: the first sample fills every tap (left-edge replication),
   // later samples shift in, and FLUSH repeats the newest tap (right edge).
   always_comb begin
      for (int k = 0; k < 5; k++) win_nx[k] = win[k];
      if (state == RUN && in_cnt == 8'd0) begin
         for (int k = 0; k < 5; k++) win_nx[k] = in_data;
      end else begin
         for (int k = 0; k < 4; k++) win_nx[k] = win[k+1];
         win_nx[4] = (state == RUN) ? in_data : win[4];
      end
   end

   // Kernel evaluated on the post-shift window; centre tap is win_nx[2].
   always_comb begin
      acc = '0;
      case (str_q)
         2'd1: acc = ACC_W'(win_nx[1]) * ACC_W'(4) + ACC_W'(win_nx[2]) * ACC_W'(8) +
                     ACC_W'(win_nx[3]) * ACC_W'(4);
         2'd2: acc = ACC_W'(win_nx[1]) * ACC_W'(5) + ACC_W'(win_nx[2]) * ACC_W'(6) +
                     ACC_W'(win_nx[3]) * ACC_W'(5);
         2'd3: acc = ACC_W'(win_nx[0]) * ACC_W'(2) + ACC_W'(win_nx[1]) * ACC_W'(4) +
                     ACC_W'(win_nx[2]) * ACC_W'(4) + ACC_W'(win_nx[3]) * ACC_W'(4) +
                     ACC_W'(win_nx[4]) * ACC_W'(2);
         default: acc = '0;
      endcase
      rnd  = acc + ACC_W'(8);
      filt = rnd[ACC_W-1:4];
      res  = (prod_cnt == 8'd0 || str_q == 2'd0) ? win_nx[2] : filt;
   end

   // Sample window register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 5; k++) win[k] <= '0;
      end else if (shift_en) begin
         for (int k = 0; k < 5; k++) win[k] <= win_nx[k];
      end
   end

   // Control FSM with registered output stage and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         str_q     <= 2'd0;
         sz_q      <= 8'd0;
         in_cnt    <= 8'd0;
         prod_cnt  <= 8'd0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (produce) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= (prod_cnt == 8'(sz_q - 8'd1));
            prod_cnt  <= 8'(prod_cnt + 8'd1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  sz_q     <= sz;
                  str_q    <= (strength <= 10'd3) ? strength[1:0] : 2'd0;
                  in_cnt   <= 8'd0;
                  prod_cnt <= 8'd0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (in_fire) begin
                  in_cnt <= 8'(in_cnt + 8'd1);
                  if (in_cnt == 8'(sz_q - 8'd1)) state <= FLUSH;
               end
            end
            FLUSH: begin
               if (out_valid && out_ready && out_last) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intra_edge_filter.sv
// Directed bench for intra_edge_filter: table of hand-computed edges plus
// sequences for backpressure, ignored restart and mid-edge reset.

module tb_intra_edge_filter;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [9:0] strength;
   logic [7:0] sz;
   logic       busy;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_data;
   logic       out_last;
   logic       done;

   intra_edge_filter #(.BIT_DEPTH(10), .MAX_SZ(129)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .strength  (strength),
      .sz        (sz),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cur_e [0:199];
   int cur_x [0:199];

   typedef struct {
      int str;
      int n;
      int off;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Runs one edge from cur_e, checks against cur_x. mode 1 toggles out_ready.
   // restart_at >= 0 pulses a conflicting start at that loop cycle.
   task automatic run_edge(input int str, input int n, input int mode,
                           input int restart_at, input string name);
      int       in_idx;
      int       out_idx;
      int       last_cyc;
      bit       saw_done;
      bit       prev_stall;
      bit       stall_err;
      bit       rdy_err;
      logic [9:0] prev_data;
      @(negedge clk);
      strength = 10'(str);
      sz       = 8'(n);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      strength = 10'd0;
      sz       = 8'd0;
      chk({name, "_busy_start"}, int'(busy), 1);
      in_idx = 0; out_idx = 0; last_cyc = -10;
      saw_done = 0; prev_stall = 0; stall_err = 0; rdy_err = 0; prev_data = '0;
      for (int cyc = 0; cyc < 3000 && !saw_done; cyc++) begin
         in_valid  = (in_idx < n);
         in_data   = (in_idx < n) ? 10'(cur_e[in_idx]) : 10'd0;
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         if (cyc == restart_at) begin
            start = 1'b1; strength = 10'd1; sz = 8'd3;
         end else begin
            start = 1'b0;
         end
         #1;
         if (prev_stall && (!out_valid || out_data != prev_data)) stall_err = 1;
         if (out_valid && !out_ready && in_ready) rdy_err = 1;
         if (done) begin
            saw_done = 1;
            chk({name, "_done_timing"}, cyc, last_cyc + 1);
            chk({name, "_out_count"}, out_idx, n);
         end
         if (in_valid && in_ready) in_idx++;
         if (out_valid && out_ready) begin
            if (out_idx < n) begin
               chk($sformatf("%s_data[%0d]", name, out_idx), int'(out_data), cur_x[out_idx]);
               chk($sformatf("%s_last[%0d]", name, out_idx), int'(out_last),
                   (out_idx == n - 1) ? 1 : 0);
            end else begin
               chk({name, "_extra_output"}, out_idx, n - 1);
            end
            out_idx++;
            last_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk({name, "_done_seen"}, int'(saw_done), 1);
      chk({name, "_in_count"}, in_idx, n);
      if (mode != 0) begin
         chk({name, "_stall_hold"}, int'(stall_err), 0);
         chk({name, "_stall_in_ready"}, int'(rdy_err), 0);
      end
      #1;
      chk({name, "_busy_end"}, int'(busy), 0);
   endtask

   vec_t vecs [7];
   int   samp [0:22];
   int   expv [0:22];

   initial begin
      int outs;
      vecs[0] = '{str: 3, n: 6, off: 0};
      vecs[1] = '{str: 1, n: 5, off: 6};
      vecs[2] = '{str: 2, n: 2, off: 11};
      vecs[3] = '{str: 0, n: 2, off: 13};
      vecs[4] = '{str: 3, n: 1, off: 15};
      vecs[5] = '{str: 7, n: 4, off: 16};
      vecs[6] = '{str: 2, n: 3, off: 20};
      samp = '{0,0,0,16,16,16,  0,0,64,0,0,  100,200,  100,200,  77,
               5,900,3,1023,  0,160,0};
      expv = '{0,2,6,10,14,16,  0,16,32,16,0,  100,169,  100,200,  77,
               5,900,3,1023,  0,60,50};

      rst_n = 1'b0; start = 1'b0; strength = '0; sz = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // sz=0 start must be ignored
      @(negedge clk);
      strength = 10'd1; sz = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("sz0_busy", int'(busy), 0);
      chk("sz0_in_ready", int'(in_ready), 0);

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            cur_e[i] = samp[vecs[v].off + i];
            cur_x[i] = expv[vecs[v].off + i];
         end
         run_edge(vecs[v].str, vecs[v].n, 0, -1, $sformatf("vec%0d", v));
      end

      // long edge, constant full-scale, toggling backpressure
      for (int i = 0; i < 129; i++) begin
         cur_e[i] = 1023;
         cur_x[i] = 1023;
      end
      run_edge(3, 129, 1, -1, "long");

      // restart attempt mid-edge is ignored
      for (int i = 0; i < 6; i++) begin
         cur_e[i] = samp[i];
         cur_x[i] = expv[i];
      end
      run_edge(3, 6, 1, 3, "restart");

      // reset after 3 outputs of a 10-sample edge
      @(negedge clk);
      strength = 10'd3; sz = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      outs = 0;
      for (int cyc = 0; cyc < 100 && outs < 3; cyc++) begin
         in_valid = 1'b1;
         in_data  = 10'(cyc * 50);
         out_ready = 1'b1;
         #1;
         if (out_valid && out_ready) outs++;
         @(negedge clk);
      end
      chk("mid_outs", outs, 3);
      chk("mid_busy_before", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_data", int'(out_data), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cur_e[i] = samp[i];
         cur_x[i] = expv[i];
      end
      run_edge(3, 6, 0, -1, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
